// File: rtl/rf_dump_ctrl.sv
// rf_dump_ctrl: read-side register-file dump sequencer.
// Walks RF entries 0..RFDEPTH-1 through a spare read port and streams each
// word out little-endian, one byte per valid/ready transfer.
// Optional feature macro: RF_DUMP_CHECKSUM_EN appends one XOR checksum byte.
module rf_dump_ctrl #(
  parameter int DATAWIDTH = 64,
  parameter int RFDEPTH   = 4,
  parameter int ADDRW     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [ADDRW-1:0]     rf_raddr,
  input  logic [DATAWIDTH-1:0] rf_rdata,
  output logic [7:0]           out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last
);

  localparam int NB  = DATAWIDTH / 8;
  localparam int BCW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [BCW-1:0]   LAST_BYTE = BCW'(NB - 1);
  localparam logic [ADDRW-1:0] LAST_IDX  = ADDRW'(RFDEPTH - 1);

`ifdef RF_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LOAD, SEND, CKSUM, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD, SEND, DONE} state_t;
`endif

  state_t               state, state_n;
  logic [ADDRW-1:0]     idx;
  logic [BCW-1:0]       bcnt;
  logic [DATAWIDTH-1:0] shift;
  logic                 xfer;
  logic                 last_byte;
  logic                 last_data;

  assign xfer      = out_valid & out_ready;
  assign last_byte = (bcnt == LAST_BYTE);
  assign last_data = last_byte && (idx == LAST_IDX);

`ifdef RF_DUMP_CHECKSUM_EN
  logic [7:0] cksum;

  // Running XOR of every data byte accepted in this dump.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cksum <= '0;
    end else if (state == IDLE && start) begin
      cksum <= '0;
    end else if (state == SEND && xfer) begin
      cksum <= cksum ^ shift[7:0];
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Entry index, byte counter and the word shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx   <= '0;
      bcnt  <= '0;
      shift <= '0;
    end else begin
      case (state)
        IDLE: idx <= '0;
        LOAD: begin
          shift <= rf_rdata;
          bcnt  <= '0;
        end
        SEND: begin
          if (xfer) begin
            shift <= shift >> 8;
            if (!last_byte) bcnt <= bcnt + 1'b1;
            else if (idx != LAST_IDX) idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_n   = state;
    busy      = 1'b0;
    done      = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    rf_raddr  = '0;
    case (state)
      IDLE: if (start) state_n = LOAD;
      LOAD: begin
        busy     = 1'b1;
        rf_raddr = idx;
        state_n  = SEND;
      end
      SEND: begin
        busy      = 1'b1;
        rf_raddr  = idx;
        out_valid = 1'b1;
        out_data  = shift[7:0];
`ifdef RF_DUMP_CHECKSUM_EN
        out_last  = 1'b0;
`else
        out_last  = last_data;
`endif
        if (xfer && last_byte) begin
          if (!last_data) state_n = LOAD;
`ifdef RF_DUMP_CHECKSUM_EN
          else state_n = CKSUM;
`else
          else state_n = DONE;
`endif
        end
      end
`ifdef RF_DUMP_CHECKSUM_EN
      CKSUM: begin
        busy      = 1'b1;
        rf_raddr  = idx;
        out_valid = 1'b1;
        out_data  = cksum;
        out_last  = 1'b1;
        if (xfer) state_n = DONE;
      end
`endif
      DONE: begin
        busy     = 1'b1;
        rf_raddr = idx;
        done     = 1'b1;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/rf_dump_ctrl.md
# rf_dump_ctrl

Read-side sequencer for the 4-entry, 64-bit register file. On a start pulse it walks every register through one RF read port (`rf_raddr`/`rf_rdata`) and streams the contents out as bytes over a valid/ready interface to the host/debug path. It sits beside the datapath on a spare RF read port, so the dump needs no datapath stall.

## Interface
Parameters:
- `DATAWIDTH`, default 64: RF word width; must be a multiple of 8.
- `RFDEPTH`, default 4: number of RF entries dumped.
- `ADDRW`, default 2: RF address width; equals clog2(`RFDEPTH`).

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset; asynchronous, active-high.
- `start`  in  1: dump request; sampled only in IDLE.
- `busy`  out  1: high from the cycle after an accepted start until DONE is left.
- `done`  out  1: one-cycle pulse after the final byte is accepted.
- `rf_raddr`  out  ADDRW: RF read address.
- `rf_rdata`  in  DATAWIDTH: RF read data; combinational from `rf_raddr`.
- `out_data`  out  8: stream byte.
- `out_valid`  out  1: `out_data` is valid.
- `out_ready`  in  1: sink accepts; a transfer is `out_valid & out_ready` at a clock edge.
- `out_last`  out  1: marks the final byte of the dump; qualified by `out_valid`.

## Operation
- FSM states: IDLE, LOAD, SEND, CKSUM, DONE. CKSUM is present only with the macro.
- IDLE: `rf_raddr`=0, `busy`=0. When `start`=1, go to LOAD with entry index 0.
- LOAD: `rf_raddr` = entry index. Capture `rf_rdata` into a DATAWIDTH shift register and clear the byte counter. Go to SEND.
- SEND: `out_valid`=1 and `out_data` = shift[7:0]. Bytes go out little-endian: byte 0 is bits [7:0].
  - On each transfer, shift right by 8 and increment the byte counter.
  - After transfer of byte DATAWIDTH/8-1: if index < RFDEPTH-1, increment the index and go to LOAD.
  - Otherwise go to CKSUM if compiled in, else DONE.
- CKSUM: `out_valid`=1 and `out_data` = running XOR of every data byte sent. Go to DONE on transfer.
- DONE: `done`=1 for one cycle, then go to IDLE.
- Handshake rules:
  - While `out_valid`=1 and `out_ready`=0, `out_data` and `out_last` hold stable.
  - `out_valid` never drops without a transfer, except on reset.
- Snapshot rule: each entry is sampled at its own LOAD cycle. RF writes to entries not yet loaded appear in the dump. Writes to entries already loaded do not.
- `start` is ignored outside IDLE, including a `start` held high during DONE.
- Index and byte counters never wrap mid-dump. A dump always emits exactly RFDEPTH*DATAWIDTH/8 data bytes, plus the checksum byte if compiled in.

## Timing
- Reset (asynchronous):
  - State goes to IDLE.
  - `busy`, `done`, `out_valid`, `out_last` go to 0; `out_data`=0 and `rf_raddr`=0.
  - The checksum is cleared.
  - A reset mid-dump aborts the dump with no `done` pulse. The next `start` begins again from entry 0.
- Start: `start` sampled high at edge E0. LOAD occupies the cycle after E0, with `busy`=1 and `rf_raddr`=0. The first byte is valid in the cycle after edge E1.
- With `out_ready` held at 1:
  - Each entry takes 1 LOAD cycle + DATAWIDTH/8 SEND cycles.
  - Defaults: 4×9 = 36 cycles, plus 1 CKSUM cycle if enabled, then 1 DONE cycle.
- Bubble: there is exactly one cycle with `out_valid`=0 between entries (the LOAD cycle).
- Backpressure: each `out_ready`=0 cycle during SEND/CKSUM adds exactly one cycle.

## Configuration
- `RF_DUMP_CHECKSUM_EN` defined: after the last data byte, emit one extra byte equal to the XOR of all data bytes. `out_last` is on the checksum byte only.
- Not defined: no CKSUM state and no checksum logic. `out_last` is on the final data byte (entry RFDEPTH-1, byte DATAWIDTH/8-1).

## Test plan
- Preload R0..R3 = 0x0807060504030201, 0x100F0E0D0C0B0A09, 0x0, 0xFFFFFFFFFFFFFFFF; pulse `start` with `out_ready`=1 -> bytes 0x01..0x10, then 8×0x00, then 8×0xFF. Dump takes 36 cycles; `done` pulses once; with the macro, the extra byte is 0x10 and `out_last` is on it.
- Same preload, `out_ready` toggling 1,0,0,1 -> identical byte sequence; `out_data` stable during stalls; each stall cycle extends the dump by one cycle.
- Write R3 = 0xAA..AA while byte 2 of R0 is pending, and write R0 = 0x55..55 in the same window -> dump shows the original R0 and the new R3 = 0xAA bytes.
- Assert `start` during SEND and during DONE -> ignored; exactly one dump and one `done` pulse.
- Assert `rst` while sending R1 byte 4 -> `out_valid`/`busy` drop immediately and no `done`. A new `start` then dumps from R0 byte 0.
- After reset, with no `start` -> `rf_raddr`=0, `out_valid`=0, `busy`=0 for 20 cycles.
